// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: state codes,
// opcodes, ALU/PC select encodings and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_BRIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       imm_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-controls decoder. mem_rdy gates the register/PC
// writes of a FETCH that is still waiting on memory.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_rdy,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.imm_write  = 1'b1;
        ctrl.alu_src_b  = SRCB_BRIMM;
        ctrl.illegal_op = !op_known(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM. Define MC_MEMWAIT_EN to make FETCH,
// MEMRD and MEMWR wait on mem_ready; otherwise memory is single-cycle.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               imm_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;
  logic   mem_rdy;

`ifdef MC_MEMWAIT_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_out_decode u_dec (
    .state   (state_q),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  // Reset silences every control immediately, even before the next edge.
  always_comb begin
    ctrl_g = '0;
    if (reset) ctrl_g = ctrl;
  end

  assign pc_write   = ctrl_g.pc_write;
  assign ir_write   = ctrl_g.ir_write;
  assign imm_write  = ctrl_g.imm_write;
  assign mem_read   = ctrl_g.mem_read;
  assign mem_write  = ctrl_g.mem_write;
  assign iord       = ctrl_g.iord;
  assign reg_write  = ctrl_g.reg_write;
  assign reg_dst    = ctrl_g.reg_dst;
  assign mem_to_reg = ctrl_g.mem_to_reg;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign alu_op     = ctrl_g.alu_op;
  assign pc_src     = ctrl_g.pc_src;
  assign illegal_op = ctrl_g.illegal_op;
  assign state      = reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-instruction state sequences
// and control words, checked every cycle through a scoreboard queue.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, imm_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .imm_write(imm_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic             zero;
    int               len;
    logic [5:0][3:0]  seq;
    logic [5:0]       rdy;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  vec_t vecs[$];
  exp_t scb[$];
  int   total = 0;
  int   bad = 0;

  wire [16:0] ctl_act = {pc_write, ir_write, imm_write, mem_read, mem_write, iord,
                         reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                         alu_op, pc_src, illegal_op};

  function automatic logic [5:0][3:0] s6(input state_e a, b, c, d, e, f);
    logic [5:0][3:0] s;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d; s[4] = e; s[5] = f;
    return s;
  endfunction

  function automatic vec_t mkv(input string n, input logic [5:0] op, input logic z,
                               input int len, input logic [5:0][3:0] seq,
                               input logic [5:0] rdy);
    vec_t v;
    v.name = n; v.op = op; v.zero = z; v.len = len; v.seq = seq; v.rdy = rdy;
    return v;
  endfunction

  // Expected control word straight from the state table
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic z,
                                           input logic rdy, input logic [5:0] op);
    logic pw, irw, immw, mr, mw, io, rw, rd, m2r, sa, ill;
    logic [1:0] srcb, aop, psrc;
    {pw, irw, immw, mr, mw, io, rw, rd, m2r, sa, ill} = '0;
    srcb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      4'd0:  begin pw = rdy; irw = rdy; mr = 1'b1; srcb = 2'd1; end
      4'd1:  begin
        immw = 1'b1; srcb = 2'd3;
        case (op)
          6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: ill = 1'b0;
          default: ill = 1'b1;
        endcase
      end
      4'd2:  begin sa = 1'b1; srcb = 2'd2; end
      4'd3:  begin io = 1'b1; mr = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin io = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; aop = 2'd2; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; aop = 2'd1; psrc = 2'd1; pw = z; end
      4'd9:  begin sa = 1'b1; srcb = 2'd2; end
      4'd10: rw = 1'b1;
      4'd11: begin psrc = 2'd2; pw = 1'b1; end
      default: ;
    endcase
    return {pw, irw, immw, mr, mw, io, rw, rd, m2r, sa, srcb, aop, psrc, ill};
  endfunction

  task automatic check(input string nm, input int cyc, input logic [16:0] got,
                       input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    logic r;
    for (int i = 0; i < v.len; i++) begin
      @(negedge CLK);
      reset = 1'b1;
      zero  = v.zero;
      // opcode only matters in DECODE/MEMADR; scramble it everywhere else
      if (v.seq[i] == S_DECODE || v.seq[i] == S_MEMADR) opcode = v.op;
      else opcode = 6'($urandom_range(0, 63));
`ifdef MC_MEMWAIT_EN
      r = v.rdy[i];
      mem_ready = r;
`else
      r = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
`endif
      e.st  = v.seq[i];
      e.ctl = exp_ctrl(v.seq[i], v.zero, r, opcode);
      scb.push_back(e);
      #1;
      e = scb.pop_front();
      check({v.name, " state"}, i, 17'(state), 17'(e.st));
      check({v.name, " ctl"}, i, ctl_act, e.ctl);
    end
  endtask

  task automatic reset_cycle(input int k);
    @(negedge CLK);
    reset  = 1'b0;
    opcode = 6'($urandom_range(0, 63));
    #1;
    check("rst state", k, 17'(state), 17'd0);
    check("rst ctl", k, ctl_act, 17'd0);
  endtask

  initial begin
    vecs.push_back(mkv("lw", 6'b100011, 1'b1, 5,
      s6(S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH), 6'h3f));
    vecs.push_back(mkv("sw", 6'b101011, 1'b0, 4,
      s6(S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("rtype", 6'b000000, 1'b0, 4,
      s6(S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("addi", 6'b001000, 1'b1, 4,
      s6(S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("beq_z1", 6'b000100, 1'b1, 3,
      s6(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("beq_z0", 6'b000100, 1'b0, 3,
      s6(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("j", 6'b000010, 1'b0, 3,
      s6(S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("ill_3f", 6'b111111, 1'b0, 2,
      s6(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
    vecs.push_back(mkv("ill_03", 6'b000011, 1'b1, 2,
      s6(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
`ifdef MC_MEMWAIT_EN
    vecs.push_back(mkv("sw_wait", 6'b101011, 1'b0, 6,
      s6(S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR), 6'b100111));
    vecs.push_back(mkv("lw_fwait", 6'b100011, 1'b0, 6,
      s6(S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB), 6'b111110));
`endif

    reset_cycle(0);
    reset_cycle(1);

    foreach (vecs[k]) run(vecs[k]);

    // Abort lw in MEMRD: three cycles of reset, then clean FETCH
    run(mkv("lw_pre", 6'b100011, 1'b0, 3,
      s6(S_FETCH, S_DECODE, S_MEMADR, S_FETCH, S_FETCH, S_FETCH), 6'h3f));
    for (int k = 0; k < 3; k++) reset_cycle(10 + k);
    run(mkv("post_rst", 6'b000000, 1'b0, 4,
      s6(S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_FETCH, S_FETCH), 6'h3f));
    run(mkv("tail_j", 6'b000010, 1'b1, 3,
      s6(S_FETCH, S_DECODE, S_JUMP, S_FETCH, S_FETCH, S_FETCH), 6'h3f));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- REQ-001: Parameter STATE_W, default 4: width of the exported state code.
- REQ-002: Port CLK, input, 1: sole clock; all state changes on its rising edge.
- REQ-003: Port reset, input, 1: synchronous, active-low reset.
- REQ-004: Port opcode, input, 6: instruction[31:26] from the instruction register.
- REQ-005: Port zero, input, 1: ALU zero flag for beq.
- REQ-006: Port mem_ready, input, 1: memory-done handshake. Only used when MC_MEMWAIT_EN is defined.
- REQ-007: Port pc_write, ir_write, imm_write, output, 1 each: enables for the PC, instruction register and stored-immediate register.
- REQ-008: Port mem_read, mem_write, iord, output, 1 each: memory strobes and the address-select signal (1 selects ALUOut).
- REQ-009: Port reg_write, reg_dst, mem_to_reg, output, 1 each: register-file controls.
- REQ-010: Port alu_src_a, output, 1; alu_src_b, output, 2; alu_op, output, 2: ALU operand and operation selects.
- REQ-011: Port pc_src, output, 2: next-PC select (0 = ALU, 1 = ALUOut, 2 = jump target).
- REQ-012: Port illegal_op, output, 1: one-cycle pulse on an unknown opcode.
- REQ-013: Port state, output, STATE_W: current FSM state code, for debug.

Function
- REQ-014: The controller is a Moore FSM with these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- REQ-015: FETCH asserts mem_read, ir_write and pc_write, with alu_src_b=1 and pc_src=0 (PC+4), then goes to DECODE.
- REQ-016: DECODE asserts imm_write with alu_src_b=3, so the stored immediate and the branch target are captured in this cycle.
- REQ-017: DECODE dispatches on opcode:
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000000 (R-type) goes to EXEC.
  - 000100 (beq) goes to BRANCH.
  - 001000 (addi) goes to ADDIEX.
  - 000010 (j) goes to JUMP.
  - Any other opcode goes to FETCH and pulses illegal_op.
- REQ-018: MEMADR sets alu_src_a=1 and alu_src_b=2, then goes to MEMRD for lw or MEMWR for sw.
- REQ-019: MEMRD sets iord=1 and mem_read=1, then goes to MEMWB. MEMWB sets reg_write=1 and mem_to_reg=1, then goes to FETCH.
- REQ-020: MEMWR sets iord=1 and mem_write=1, then goes to FETCH.
- REQ-021: EXEC sets alu_src_a=1 and alu_op=2, then goes to ALUWB. ALUWB sets reg_write=1 and reg_dst=1, then goes to FETCH.
- REQ-022: BRANCH sets alu_src_a=1, alu_op=1 and pc_src=1; pc_write is asserted only when zero=1; then goes to FETCH.
- REQ-023: ADDIEX sets alu_src_a=1 and alu_src_b=2, then goes to ADDIWB. ADDIWB sets reg_write=1 and reg_dst=0, then goes to FETCH.
- REQ-024: JUMP sets pc_src=2 and pc_write=1, then goes to FETCH.
- REQ-025: Every control output not named for the current state is 0.
- REQ-026: Latency without wait states, counted FETCH to FETCH: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- REQ-027: opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.

Reset
- REQ-028: While reset=0 at a CLK edge, state goes to FETCH.
- REQ-029: While reset=0, all control outputs and illegal_op are forced to 0, and state reads 0 (FETCH).
- REQ-030: Reset asserted in any state, including mid-instruction, aborts the instruction with no further write enables.
- REQ-031: The first cycle after reset is released is FETCH.

Configuration
- REQ-032: The macro MC_MEMWAIT_EN selects the memory handshake.
- REQ-033: With MC_MEMWAIT_EN defined, FETCH, MEMRD and MEMWR hold their state and their strobes while mem_ready=0. ir_write, pc_write and reg_write are asserted only in the cycle where mem_ready=1.
- REQ-034: Without MC_MEMWAIT_EN, mem_ready is ignored and memory is treated as single-cycle.

Structure
- REQ-035: A shared package mc_pkg holds:
  - the state enumeration;
  - opcode constants;
  - alu_op, alu_src_b and pc_src encodings.
- REQ-036: Sub-module mc_out_decode is the combinational state-to-controls decoder. The FSM register and next-state logic remain in multicycle_ctrl.

Verification
- REQ-037: Hold reset=0 for 3 cycles in the middle of the lw MEMRD state; all enables must stay 0, and state=FETCH in the first cycle after release.
- REQ-038: Run opcode 100011, zero=x, mem_ready=1. Required sequence: FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. reg_write=1 only in MEMWB, and imm_write=1 only in DECODE.
- REQ-039: Run beq (000100) twice, once with zero=1 and once with zero=0. pc_write is asserted in BRANCH with pc_src=1 only for the zero=1 run; both runs take 3 cycles.
- REQ-040: Apply opcode 111111. illegal_op pulses for exactly one cycle in DECODE, then the FSM returns to FETCH with no reg_write or mem_write.
- REQ-041: With MC_MEMWAIT_EN defined, run sw with mem_ready low for 2 cycles in MEMWR. mem_write must stay high for 3 cycles and the instruction must take 6 cycles in total.
- REQ-042: Run j (000010). The bench must observe pc_src=2 and pc_write=1 in JUMP, and 3 cycles total.
